// File: rtl/control_unit.sv
// Multicycle control FSM for the RV64 datapath: FETCH/DECODE/EXECUTE/[MEM]/[WRITEBACK]/FINISH.
// Strobes are flops loaded from the next state; MEM stalls on mem_ready under a MAX_WAIT watchdog.
module control_unit #(
  parameter int WORDSIZE = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  output logic                fetch,
  output logic                decode,
  output logic                rf_write_en,
  output logic                dm_write_en,
  output logic                mem_read,
  output logic                finished,
  output logic                halted,
  output logic                illegal_instr,
  output logic                mem_timeout,
  output logic [WORDSIZE-1:0] instr_count
);

  // Wait counter only ever holds 0..MAX_WAIT-1.
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_FINISH, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_SYSTEM, C_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return C_ALU;
      7'b0000011:                         return C_LOAD;
      7'b0100011:                         return C_STORE;
      7'b1100011:                         return C_BRANCH;
      7'b1110011:                         return C_SYSTEM;
      default:                            return C_ILLEGAL;
    endcase
  endfunction

  state_t        state, nxt_state;
  logic [6:0]    op_q, nxt_op;
  logic [WW-1:0] wait_cnt, nxt_wait;
  logic          set_illegal, set_timeout;
  op_class_t     cur_cls, nxt_cls;

  assign cur_cls = classify(op_q);
  assign nxt_cls = classify(nxt_op);

  always_comb begin
    nxt_state   = state;
    nxt_op      = op_q;
    nxt_wait    = wait_cnt;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE:   if (run) nxt_state = S_FETCH;
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        nxt_op = opcode;
        case (classify(opcode))
          C_SYSTEM:  nxt_state = S_HALT;
          C_ILLEGAL: begin
            nxt_state   = S_HALT;
            set_illegal = 1'b1;
          end
          default:   nxt_state = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (cur_cls)
          C_LOAD, C_STORE: begin
            nxt_state = S_MEM;
            nxt_wait  = '0;
          end
          C_BRANCH: nxt_state = S_FINISH;
          default:  nxt_state = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt_wait  = '0;
          nxt_state = (cur_cls == C_LOAD) ? S_WRITEBACK : S_FINISH;
        end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
          nxt_state   = S_HALT;
          set_timeout = 1'b1;
        end else begin
          nxt_wait = wait_cnt + WW'(1);
        end
      end
      S_WRITEBACK: nxt_state = S_FINISH;
      S_FINISH:    nxt_state = run ? S_FETCH : S_IDLE;
      default:     nxt_state = S_HALT;
    endcase
  end

  // Outputs are registered images of the next state so they never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      wait_cnt      <= '0;
      fetch         <= 1'b0;
      decode        <= 1'b0;
      rf_write_en   <= 1'b0;
      dm_write_en   <= 1'b0;
      mem_read      <= 1'b0;
      finished      <= 1'b0;
      halted        <= 1'b0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
      instr_count   <= '0;
    end else begin
      state         <= nxt_state;
      op_q          <= nxt_op;
      wait_cnt      <= nxt_wait;
      fetch         <= (nxt_state == S_FETCH);
      decode        <= (nxt_state == S_DECODE);
      rf_write_en   <= (nxt_state == S_WRITEBACK);
      dm_write_en   <= (nxt_state == S_MEM) && (nxt_cls == C_STORE);
      mem_read      <= (nxt_state == S_MEM) && (nxt_cls == C_LOAD);
      finished      <= (nxt_state == S_FINISH);
      halted        <= (nxt_state == S_HALT);
      illegal_instr <= illegal_instr | set_illegal;
      mem_timeout   <= mem_timeout | set_timeout;
      if (state == S_FINISH) instr_count <= instr_count + WORDSIZE'(1);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction timing model.
module tb_control_unit;

  localparam int MAXW = 15;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        fetch, decode, rf_write_en, dm_write_en, mem_read, finished;
  logic        halted, illegal_instr, mem_timeout;
  logic [63:0] instr_count;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_count = '0;
  logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};

  control_unit #(.WORDSIZE(64), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .fetch(fetch), .decode(decode), .rf_write_en(rf_write_en), .dm_write_en(dm_write_en),
    .mem_read(mem_read), .finished(finished), .halted(halted),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Step strobes must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ($countones({fetch, decode, rf_write_en, dm_write_en, mem_read, finished}) > 1) begin
        failures++;
        $display("FAIL onehot t=%0t strobes=%b required at most one high", $time,
                 {fetch, decode, rf_write_en, dm_write_en, mem_read, finished});
      end
    end
  end

  // Reference model: instruction timing from the class table.
  function automatic bit is_load(input logic [6:0] op);  return op == OP_LOAD;  endfunction
  function automatic bit is_store(input logic [6:0] op); return op == OP_STORE; endfunction
  function automatic int exp_lat(input logic [6:0] op, input int n);
    if (is_load(op))        return 6 + n;
    if (is_store(op))       return 5 + n;
    if (op == OP_BRANCH)    return 4;
    return 5;
  endfunction
  function automatic int exp_mem(input logic [6:0] op, input int n);
    return (is_load(op) || is_store(op)) ? n + 1 : 0;
  endfunction
  function automatic int exp_rf(input logic [6:0] op);
    return (is_store(op) || op == OP_BRANCH) ? 0 : 1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_count = '0;
    @(negedge clk);
  endtask

  // Drives one instruction; mem_ready is held low for n_wait MEM cycles, then high.
  task automatic exec_instr(input logic [6:0] op, input int n_wait, input bit drop_run,
                            output int lat, output int first_fetch, output int n_mem,
                            output int n_rf, output logic [63:0] cnt_fetch, output bit halt_seen);
    int cyc, k;
    bit started, prev_dec;
    lat = 0; first_fetch = 0; n_mem = 0; n_rf = 0; cnt_fetch = '0; halt_seen = 0;
    cyc = 0; k = 0; started = 0; prev_dec = 0;
    opcode = op;
    run = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (fetch && !started) begin
        started = 1; first_fetch = i; cnt_fetch = instr_count;
      end
      if (started) cyc++;
      if (prev_dec) begin
        opcode = 7'($urandom);
        if (drop_run) run = 1'b0;
      end
      prev_dec = decode;
      if (mem_read || dm_write_en) begin
        n_mem++;
        mem_ready = (k >= n_wait);
        k++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (rf_write_en) n_rf++;
      if (finished) begin lat = cyc; return; end
      if (halted) begin halt_seen = 1; return; end
    end
    failures++;
    $display("FAIL exec_bound op=%b no finished/halted within 64 cycles", op);
  endtask

  int lat, ff, nm, nr; logic [63:0] cf; bit hs;

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b0;
    #1;
    checks++;
    if ({fetch, decode, rf_write_en, dm_write_en, mem_read, finished, halted, illegal_instr,
         mem_timeout} !== 9'b0 || instr_count !== 64'd0) begin
      failures++; $display("FAIL reset_outputs got some nonzero, count=%0d required all 0", instr_count);
    end
    apply_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (fetch !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL idle_hold fetch=%b halted=%b required 0 0 with run=0", fetch, halted);
    end
  endtask

  task automatic test_alu_back_to_back();
    for (int i = 0; i < 3; i++) begin
      exec_instr(OP_R, 0, 0, lat, ff, nm, nr, cf, hs);
      checks++; if (lat !== 5) begin failures++; $display("FAIL alu_lat got %0d required 5", lat); end
      checks++; if (ff !== 1) begin failures++; $display("FAIL alu_b2b fetch at %0d required 1", ff); end
      checks++; if (nr !== 1) begin failures++; $display("FAIL alu_rf got %0d required 1", nr); end
      checks++; if (cf !== exp_count) begin failures++; $display("FAIL alu_count got %0d required %0d", cf, exp_count); end
      exp_count++;
    end
  endtask

  task automatic test_load_wait();
    exec_instr(OP_LOAD, 3, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (lat !== 9) begin failures++; $display("FAIL load_lat got %0d required 9", lat); end
    checks++; if (nm !== 4) begin failures++; $display("FAIL load_mem_read got %0d required 4", nm); end
    checks++; if (nr !== 1) begin failures++; $display("FAIL load_rf got %0d required 1", nr); end
    exp_count++;
  endtask

  task automatic test_store_branch();
    exec_instr(OP_STORE, 0, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (lat !== 5) begin failures++; $display("FAIL store_lat got %0d required 5", lat); end
    checks++; if (nm !== 1 || nr !== 0) begin failures++; $display("FAIL store_strobes dm=%0d rf=%0d required 1 0", nm, nr); end
    exp_count++;
    exec_instr(OP_BRANCH, 0, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (lat !== 4) begin failures++; $display("FAIL branch_lat got %0d required 4", lat); end
    checks++; if (nm !== 0 || nr !== 0) begin failures++; $display("FAIL branch_strobes mem=%0d rf=%0d required 0 0", nm, nr); end
    checks++; if (cf !== exp_count) begin failures++; $display("FAIL branch_count got %0d required %0d", cf, exp_count); end
    exp_count++;
  endtask

  task automatic test_random();
    logic [6:0] op; int n;
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 8)];
      n  = $urandom_range(0, MAXW - 1);
      exec_instr(op, n, 0, lat, ff, nm, nr, cf, hs);
      checks++;
      if (hs || lat !== exp_lat(op, n) || nm !== exp_mem(op, n) || nr !== exp_rf(op) ||
          cf !== exp_count || ff !== 1) begin
        failures++;
        $display("FAIL rand_instr op=%b n=%0d lat=%0d/%0d mem=%0d/%0d rf=%0d/%0d cnt=%0d/%0d ff=%0d halt=%0d",
                 op, n, lat, exp_lat(op, n), nm, exp_mem(op, n), nr, exp_rf(op), cf, exp_count, ff, hs);
      end
      exp_count++;
    end
  endtask

  task automatic test_run_drop();
    bit bad = 0;
    exec_instr(OP_I, 0, 1, lat, ff, nm, nr, cf, hs);
    checks++; if (lat !== 5 || hs) begin failures++; $display("FAIL drop_complete lat=%0d halt=%0d required 5 0", lat, hs); end
    exp_count++;
    repeat (4) begin
      @(negedge clk);
      if ({fetch, decode, rf_write_en, dm_write_en, mem_read, finished} !== 6'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL drop_idle strobes active after run=0 required idle"); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL drop_count got %0d required %0d", instr_count, exp_count); end
  endtask

  task automatic test_illegal();
    bit bad = 0;
    apply_reset();
    exec_instr(OP_BRANCH, 0, 0, lat, ff, nm, nr, cf, hs);
    exp_count++;
    exec_instr(7'b1111111, 0, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (!hs || illegal_instr !== 1'b1) begin failures++; $display("FAIL illegal_halt halt=%0d illegal=%b required 1 1", hs, illegal_instr); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL illegal_count got %0d required %0d", instr_count, exp_count); end
    repeat (8) begin
      run = 1'($urandom_range(0, 1));
      opcode = 7'($urandom);
      @(negedge clk);
      if (halted !== 1'b1 || {fetch, decode, rf_write_en, dm_write_en, mem_read, finished} !== 6'b0) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL halt_terminal left HALT or strobed, required stuck in HALT"); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || illegal_instr !== 1'b0 || instr_count !== 64'd0) begin
      failures++; $display("FAIL illegal_reset halted=%b illegal=%b count=%0d required 0 0 0", halted, illegal_instr, instr_count);
    end
    apply_reset();
  endtask

  task automatic test_system();
    exec_instr(OP_SYS, 0, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (!hs || halted !== 1'b1 || illegal_instr !== 1'b0) begin
      failures++; $display("FAIL system_halt halt=%0d illegal=%b required 1 0", hs, illegal_instr);
    end
    apply_reset();
  endtask

  task automatic test_timeout();
    exec_instr(OP_LOAD, 1000, 0, lat, ff, nm, nr, cf, hs);
    checks++; if (!hs || nm !== MAXW) begin failures++; $display("FAIL timeout_cycles halt=%0d mem=%0d required 1 %0d", hs, nm, MAXW); end
    checks++; if (mem_timeout !== 1'b1 || mem_read !== 1'b0 || illegal_instr !== 1'b0) begin
      failures++; $display("FAIL timeout_flags timeout=%b mem_read=%b illegal=%b required 1 0 0", mem_timeout, mem_read, illegal_instr);
    end
    checks++; if (instr_count !== 64'd0) begin failures++; $display("FAIL timeout_count got %0d required 0", instr_count); end
    apply_reset();
  endtask

  task automatic test_reset_mid_mem();
    bit found = 0;
    exec_instr(OP_BRANCH, 0, 0, lat, ff, nm, nr, cf, hs);
    opcode = OP_LOAD; run = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL midmem_reach mem_read never seen required within 20 cycles"); end
    @(negedge clk);
    checks++; if (instr_count !== 64'd1 || mem_read !== 1'b1) begin
      failures++; $display("FAIL midmem_pre count=%0d mem_read=%b required 1 1", instr_count, mem_read);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fetch, decode, rf_write_en, dm_write_en, mem_read, finished, halted, illegal_instr,
         mem_timeout} !== 9'b0 || instr_count !== 64'd0) begin
      failures++; $display("FAIL midmem_async_reset count=%0d mem_read=%b required all 0", instr_count, mem_read);
    end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load_wait();
    test_store_branch();
    test_random();
    test_run_drop();
    test_illegal();
    test_system();
    test_timeout();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle control FSM that drives the 64-bit RISC-V datapath.
- Consumes the opcode the datapath exports (instr[6:0]) and produces the step strobes the datapath consumes: fetch, decode, rf_write_en, dm_write_en and finished.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK/FINISH, handles data-memory wait states with a timeout watchdog, halts on SYSTEM or illegal opcodes, and counts retired instructions.

Parameters:
- WORDSIZE, 64, width of the retired-instruction counter.
- MAX_WAIT, 15, max cycles spent in MEM waiting for mem_ready before timeout (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- run  input  1  enable; level, sampled in IDLE and FINISH.
- opcode  input  7  instr[6:0] from datapath.
- mem_ready  input  1  data memory access complete, sampled in MEM.
- fetch  output  1  high during FETCH.
- decode  output  1  high during DECODE.
- rf_write_en  output  1  high during WRITEBACK.
- dm_write_en  output  1  high during MEM for stores.
- mem_read  output  1  high during MEM for loads.
- finished  output  1  one-cycle pulse in FINISH; datapath advances PC on it.
- halted  output  1  high in HALT.
- illegal_instr  output  1  sticky, unknown opcode decoded.
- mem_timeout  output  1  sticky, MAX_WAIT exceeded.
- instr_count  output  WORDSIZE  retired instructions.

Behaviour:
- Reset (async, reset_n=0, any time including mid-instruction):
  - state=IDLE; every output 0; instr_count=0; wait counter=0; latched opcode=0.
  - Effective immediately, not on the next clock edge.
- Outputs are a pure decode of the registered state plus the latched opcode. No glitches; no combinational path from any input to any output.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FINISH, HALT.
- IDLE: go to FETCH when run=1, else stay.
- FETCH → DECODE unconditionally.
- DECODE: opcode is sampled and latched at the clock edge ending DECODE. Class by opcode:
  - ALU class → EXECUTE: 0110011 R, 0010011 I-ALU, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
  - 0000011 LOAD, 0100011 STORE, 1100011 BRANCH → EXECUTE.
  - 1110011 SYSTEM → HALT.
  - Any other value → HALT and set illegal_instr.
- EXECUTE: LOAD/STORE → MEM; BRANCH → FINISH; ALU class → WRITEBACK.
- MEM:
  - mem_read=1 (LOAD) or dm_write_en=1 (STORE), held every MEM cycle.
  - Wait counter starts at 0 on entry and increments each cycle mem_ready=0.
  - mem_ready=1 → LOAD goes to WRITEBACK, STORE goes to FINISH; wait counter clears.
  - mem_ready=0 with wait counter == MAX_WAIT-1 → HALT and set mem_timeout.
  - Net: mem_ready=0 for MAX_WAIT consecutive MEM cycles → HALT.
  - mem_ready=1 on the first MEM cycle gives a zero-wait access.
- WRITEBACK → FINISH.
- FINISH:
  - finished=1 for exactly one cycle.
  - instr_count increments by 1 on the edge leaving FINISH; wraps from 2^WORDSIZE-1 to 0.
  - Next state is FETCH if run=1, else IDLE.
  - Dropping run mid-instruction completes the current instruction first.
- HALT: terminal. halted=1 and all step strobes 0. Only reset exits. instr_count does not increment for the halting instruction.
- Latency in cycles, FETCH through FINISH inclusive, zero-wait memory (N = MEM cycles with mem_ready=0):
  - BRANCH 4.
  - ALU class 5.
  - STORE 5+N.
  - LOAD 6+N.
- Back-to-back instructions with run held high: FETCH directly follows FINISH, with no bubble.
- At most one of fetch, decode, rf_write_en, dm_write_en, mem_read, finished is high in any cycle; the bench asserts this every cycle.

Test Plan:
- Reset then run=1, opcode=0110011 constant → states F,D,E,WB,FIN repeat every 5 cycles; finished pulses at cycles 5 and 10; instr_count=2 after cycle 10.
- Opcode=0000011, mem_ready low 3 cycles then high → mem_read high 4 cycles; rf_write_en 1 cycle; finished at cycle 9; instr_count=1.
- Opcode=0100011 with mem_ready=1 immediately → dm_write_en high exactly 1 cycle; no rf_write_en; finished at cycle 5. Opcode=1100011 → finished at cycle 4 with no rf_write_en or dm_write_en.
- Opcode=1111111 → HALT after DECODE; illegal_instr=1, halted=1, instr_count unchanged; run toggling has no effect; reset_n=0 clears all.
- Load with mem_ready=0 forever, MAX_WAIT=15 → HALT after 15 MEM cycles; mem_timeout=1; mem_read drops to 0.
- run dropped during EXECUTE → instruction completes, finished pulses, FSM enters IDLE. reset_n asserted mid-MEM between edges → outputs go to 0 before the next clock edge; instr_count=0.
